bus_snoop_responder: RTL and testbench
======================================

BUS_SNOOP_RESPONDER -- requirements
Module: bus_snoop_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, request address width.
REQ-002 SHALL have parameter SNOOP_LAT, default 2, snoop-phase length in cycles (legal >=1).
REQ-003 SHALL have parameter MEM_LAT, default 8, memory-phase length in cycles (legal >=1).
REQ-004 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-005 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-006 SHALL have port rstb  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  input  1  cache presents a bus operation.
REQ-008 SHALL have port req_ready  output  1  responder can accept a bus operation.
REQ-009 SHALL have port req_op  input  3  bus op: 1 READ, 2 WRITE, 3 INVALIDATE, 4 RWIM; 0,5,6,7 illegal.
REQ-010 SHALL have port req_addr  input  ADDR_W  bus operation address.
REQ-011 SHALL have port clr_cnt  input  1  synchronous clear of counters and err_op.
REQ-012 SHALL have port snp_valid  output  1  one-cycle snoop-result strobe.
REQ-013 SHALL have port snp_result  output  2  00 HIT, 01 HITM, 10 NOHIT.
REQ-014 SHALL have port done_valid  output  1  one-cycle completion strobe.
REQ-015 SHALL have port done_op  output  3  op being completed.
REQ-016 SHALL have port done_addr  output  ADDR_W  address being completed.
REQ-017 SHALL have ports cnt_read, cnt_write, cnt_inval, cnt_rwim, cnt_hitm  output  CNT_W each  completed-op and HITM counts.
REQ-018 SHALL have port err_op  output  1  sticky illegal-op flag.

Function
REQ-019 SHALL implement FSM states IDLE, SNOOP, MEM, DONE; req_ready=1 only in IDLE.
REQ-020 SHALL accept on a rising edge with req_valid=1 and req_ready=1, capturing req_op and req_addr; inputs ignored in all other states.
REQ-021 SHALL, on an accepted illegal op, remain in IDLE, set err_op, change no counter, and emit no strobes.
REQ-022 SHALL, on an accepted legal op, enter SNOOP for exactly SNOOP_LAT cycles.
REQ-023 SHALL assert snp_valid in the last SNOOP cycle only, with snp_result from captured addr[1:0]: 00->00 HIT, 01->01 HITM, 1x->10 NOHIT; snp_result=00 when snp_valid=0.
REQ-024 SHALL, after SNOOP, go to DONE for INVALIDATE, otherwise MEM for exactly MEM_LAT cycles, then DONE.
REQ-025 SHALL hold DONE one cycle with done_valid=1, done_op/done_addr = captured values (zero otherwise), then return to IDLE.
REQ-026 SHALL, with accept edge as cycle 0, place snp_valid in cycle SNOOP_LAT, done_valid in cycle SNOOP_LAT+MEM_LAT+1 (INVALIDATE: SNOOP_LAT+1), and req_ready high again the cycle after done_valid.
REQ-027 SHALL increment the counter matching the op at the DONE edge, and cnt_hitm when that op's snoop result was HITM.
REQ-028 SHALL saturate every counter at 2^CNT_W-1 (no wrap).
REQ-029 SHALL give clr_cnt priority over same-cycle increments and err_op set; clr_cnt SHALL NOT affect FSM or an op in flight.
REQ-030 SHALL treat back-to-back req_valid as independent ops; minimum spacing between accepts is SNOOP_LAT+MEM_LAT+2 cycles (INVALIDATE: SNOOP_LAT+2).

Reset
REQ-031 SHALL, on rstb=0 at any time including mid-operation, asynchronously enter IDLE and drive req_ready=1, snp_valid=0, snp_result=00, done_valid=0, done_op=0, done_addr=0, all counters=0, err_op=0.
REQ-032 SHALL emit no strobe for an operation aborted by reset and accept the first valid request on the first rising edge after rstb deasserts.

Verification
REQ-033 SHALL cover READ addr 0x0000_1003, defaults -> snp_valid cycle 2 with 10 NOHIT, done_valid cycle 11, cnt_read=1, req_ready back cycle 12.
REQ-034 SHALL cover INVALIDATE addr 0x0000_2001 -> snp 01 HITM cycle 2, done cycle 3, cnt_inval=1, cnt_hitm=1, no MEM state.
REQ-035 SHALL cover req_op=6 accepted -> err_op=1, all counters 0, no strobes, req_ready stays 1; then clr_cnt -> err_op=0.
REQ-036 SHALL cover CNT_W=2, four WRITEs addr 0x...0 -> cnt_write 1,2,3,3 (saturated), each snp_result 00 HIT.
REQ-037 SHALL cover rstb low during MEM of RWIM -> all outputs at reset values immediately, no done_valid, cnt_rwim=0; next READ completes normally.
REQ-038 SHALL cover clr_cnt asserted in the DONE cycle of a READ -> cnt_read=0 afterwards, done_valid still pulses once.

Source files
------------

// File: rtl/bus_snoop_responder.sv
// Snoop responder for a cache bus: snoop phase, optional memory phase,
// one-cycle completion strobe, plus saturating per-op statistics.
module bus_snoop_responder #(
    parameter int ADDR_W    = 32,
    parameter int SNOOP_LAT = 2,
    parameter int MEM_LAT   = 8,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              clr_cnt,
    output logic              snp_valid,
    output logic [1:0]        snp_result,
    output logic              done_valid,
    output logic [2:0]        done_op,
    output logic [ADDR_W-1:0] done_addr,
    output logic [CNT_W-1:0]  cnt_read,
    output logic [CNT_W-1:0]  cnt_write,
    output logic [CNT_W-1:0]  cnt_inval,
    output logic [CNT_W-1:0]  cnt_rwim,
    output logic [CNT_W-1:0]  cnt_hitm,
    output logic              err_op
);

    typedef enum logic [1:0] {
        IDLE,
        SNOOP,
        MEM,
        DONE
    } state_t;

    localparam int MAX_LAT = (SNOOP_LAT > MEM_LAT) ? SNOOP_LAT : MEM_LAT;
    localparam int PH_W    = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;
    localparam logic [2:0] OP_INVAL = 3'd3;
    localparam logic [2:0] OP_RWIM  = 3'd4;

    state_t            state, state_nx;
    logic [PH_W-1:0]   ph_cnt, ph_nx;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic              accept, legal, snp_last, mem_last, is_hitm;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_comb begin
        accept     = req_valid && (state == IDLE);
        legal      = (req_op != 3'd0) && (req_op <= OP_RWIM);
        snp_last   = (state == SNOOP) && (ph_cnt == PH_W'(SNOOP_LAT - 1));
        mem_last   = (state == MEM) && (ph_cnt == PH_W'(MEM_LAT - 1));
        is_hitm    = (addr_q[1:0] == 2'b01);
        state_nx   = state;
        ph_nx      = ph_cnt;
        req_ready  = (state == IDLE);
        snp_valid  = snp_last;
        snp_result = 2'b00;
        done_valid = (state == DONE);
        done_op    = '0;
        done_addr  = '0;
        if (snp_last)
            snp_result = addr_q[1] ? 2'b10 : {1'b0, addr_q[0]};
        unique case (state)
            IDLE: begin
                if (accept && legal) begin
                    state_nx = SNOOP;
                    ph_nx    = '0;
                end
            end
            SNOOP: begin
                if (snp_last) begin
                    ph_nx    = '0;
                    state_nx = (op_q == OP_INVAL) ? DONE : MEM;
                end else begin
                    ph_nx = ph_cnt + 1'b1;
                end
            end
            MEM: begin
                if (mem_last) begin
                    ph_nx    = '0;
                    state_nx = DONE;
                end else begin
                    ph_nx = ph_cnt + 1'b1;
                end
            end
            DONE: begin
                done_op   = op_q;
                done_addr = addr_q;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= IDLE;
            ph_cnt    <= '0;
            op_q      <= '0;
            addr_q    <= '0;
            cnt_read  <= '0;
            cnt_write <= '0;
            cnt_inval <= '0;
            cnt_rwim  <= '0;
            cnt_hitm  <= '0;
            err_op    <= 1'b0;
        end else begin
            state  <= state_nx;
            ph_cnt <= ph_nx;
            if (accept) begin
                op_q   <= req_op;
                addr_q <= req_addr;
            end
            // Clear beats any same-edge increment or error capture.
            if (clr_cnt) begin
                cnt_read  <= '0;
                cnt_write <= '0;
                cnt_inval <= '0;
                cnt_rwim  <= '0;
                cnt_hitm  <= '0;
                err_op    <= 1'b0;
            end else begin
                if (accept && !legal)
                    err_op <= 1'b1;
                if (state == DONE) begin
                    case (op_q)
                        OP_READ:  cnt_read  <= sat_inc(cnt_read);
                        OP_WRITE: cnt_write <= sat_inc(cnt_write);
                        OP_INVAL: cnt_inval <= sat_inc(cnt_inval);
                        OP_RWIM:  cnt_rwim  <= sat_inc(cnt_rwim);
                        default:  ;
                    endcase
                    if (is_hitm)
                        cnt_hitm <= sat_inc(cnt_hitm);
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_snoop_responder.sv
// Bench for bus_snoop_responder: directed scenarios then random ops,
// checked cycle by cycle against a timing/counter model.
module tb_bus_snoop_responder;

    localparam int AW = 32;
    localparam int SL = 2;
    localparam int ML = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rstb = 1'b0;
    logic          req_valid = 1'b0;
    logic [2:0]    req_op = '0;
    logic [AW-1:0] req_addr = '0;
    logic          clr_cnt = 1'b0;

    logic          req_ready, snp_valid, done_valid, err_op;
    logic [1:0]    snp_result;
    logic [2:0]    done_op;
    logic [AW-1:0] done_addr;
    logic [CW-1:0] cnt_read, cnt_write, cnt_inval, cnt_rwim, cnt_hitm;

    logic          s_req_ready, s_snp_valid, s_done_valid, s_err_op;
    logic [1:0]    s_snp_result;
    logic [2:0]    s_done_op;
    logic [AW-1:0] s_done_addr;
    logic [1:0]    s_cnt_read, s_cnt_write, s_cnt_inval, s_cnt_rwim, s_cnt_hitm;

    bus_snoop_responder #(.ADDR_W(AW), .SNOOP_LAT(SL), .MEM_LAT(ML), .CNT_W(CW)) u_dut (
        .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .clr_cnt(clr_cnt),
        .snp_valid(snp_valid), .snp_result(snp_result),
        .done_valid(done_valid), .done_op(done_op), .done_addr(done_addr),
        .cnt_read(cnt_read), .cnt_write(cnt_write), .cnt_inval(cnt_inval),
        .cnt_rwim(cnt_rwim), .cnt_hitm(cnt_hitm), .err_op(err_op)
    );

    bus_snoop_responder #(.ADDR_W(AW), .SNOOP_LAT(SL), .MEM_LAT(ML), .CNT_W(2)) u_sat (
        .clk(clk), .rstb(rstb), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_op(req_op), .req_addr(req_addr), .clr_cnt(clr_cnt),
        .snp_valid(s_snp_valid), .snp_result(s_snp_result),
        .done_valid(s_done_valid), .done_op(s_done_op), .done_addr(s_done_addr),
        .cnt_read(s_cnt_read), .cnt_write(s_cnt_write), .cnt_inval(s_cnt_inval),
        .cnt_rwim(s_cnt_rwim), .cnt_hitm(s_cnt_hitm), .err_op(s_err_op)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_cnt[4];
    int m_hitm;
    bit m_err;

    function automatic logic [63:0] sat3(input int v);
        return (v > 3) ? 64'd3 : 64'(v);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clr();
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_hitm = 0;
        m_err  = 1'b0;
    endtask

    task automatic chk_cnt();
        chk("cnt_read",    64'(cnt_read),    64'(m_cnt[0]));
        chk("cnt_write",   64'(cnt_write),   64'(m_cnt[1]));
        chk("cnt_inval",   64'(cnt_inval),   64'(m_cnt[2]));
        chk("cnt_rwim",    64'(cnt_rwim),    64'(m_cnt[3]));
        chk("cnt_hitm",    64'(cnt_hitm),    64'(m_hitm));
        chk("err_op",      64'(err_op),      64'(m_err));
        chk("s_cnt_read",  64'(s_cnt_read),  sat3(m_cnt[0]));
        chk("s_cnt_write", 64'(s_cnt_write), sat3(m_cnt[1]));
        chk("s_cnt_inval", 64'(s_cnt_inval), sat3(m_cnt[2]));
        chk("s_cnt_rwim",  64'(s_cnt_rwim),  sat3(m_cnt[3]));
        chk("s_cnt_hitm",  64'(s_cnt_hitm),  sat3(m_hitm));
        chk("s_err_op",    64'(s_err_op),    64'(m_err));
    endtask

    task automatic chk_idle_outs();
        chk("req_ready",  64'(req_ready),  64'd1);
        chk("snp_valid",  64'(snp_valid),  64'd0);
        chk("snp_result", 64'(snp_result), 64'd0);
        chk("done_valid", 64'(done_valid), 64'd0);
        chk("done_op",    64'(done_op),    64'd0);
        chk("done_addr",  64'(done_addr),  64'd0);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current (IDLE) cycle and follow it to completion.
    // clr_at: cycle index (0 = accept cycle) during which clr_cnt is high.
    task automatic do_op(input logic [2:0] op, input logic [AW-1:0] addr, input int clr_at);
        bit         legal;
        int         total;
        logic [1:0] res;
        legal = (op >= 3'd1) && (op <= 3'd4);
        total = (op == 3'd3) ? SL + 1 : SL + ML + 1;
        case (addr[1:0])
            2'b00:   res = 2'b00;
            2'b01:   res = 2'b01;
            default: res = 2'b10;
        endcase
        chk_idle_outs();
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        clr_cnt   = (clr_at == 0);
        cyc();
        if (clr_at == 0) model_clr();
        else if (!legal) m_err = 1'b1;
        if (legal) begin
            for (int c = 1; c <= total; c++) begin
                req_valid = 1'($urandom_range(0, 1));
                req_op    = 3'($urandom);
                req_addr  = $urandom;
                clr_cnt   = (clr_at == c);
                chk("busy_ready", 64'(req_ready),  64'd0);
                chk("snp_valid",  64'(snp_valid),  64'(c == SL));
                chk("snp_result", 64'(snp_result), (c == SL) ? 64'(res) : 64'd0);
                chk("done_valid", 64'(done_valid), 64'(c == total));
                chk("done_op",    64'(done_op),    (c == total) ? 64'(op) : 64'd0);
                chk("done_addr",  64'(done_addr),  (c == total) ? 64'(addr) : 64'd0);
                chk("s_snp_valid",  64'(s_snp_valid),  64'(c == SL));
                chk("s_done_valid", 64'(s_done_valid), 64'(c == total));
                chk_cnt();
                cyc();
                if (clr_at == c) begin
                    model_clr();
                end else if (c == total) begin
                    m_cnt[op - 1]++;
                    if (res == 2'b01) m_hitm++;
                end
            end
        end
        req_valid = 1'b0;
        clr_cnt   = 1'b0;
        chk_idle_outs();
        chk_cnt();
    endtask

    task automatic clear_cycle();
        clr_cnt = 1'b1;
        cyc();
        clr_cnt = 1'b0;
        model_clr();
        chk_idle_outs();
        chk_cnt();
    endtask

    initial begin
        logic [2:0] rop;
        logic [2:0] bad_ops [4];
        bad_ops[0] = 3'd0;
        bad_ops[1] = 3'd5;
        bad_ops[2] = 3'd6;
        bad_ops[3] = 3'd7;
        model_clr();
        #12;
        chk_idle_outs();
        chk_cnt();
        rstb = 1'b1;

        do_op(3'd1, 32'h0000_1003, -1);
        do_op(3'd3, 32'h0000_2001, -1);
        do_op(3'd6, 32'h0000_0000, -1);
        clear_cycle();
        for (int i = 0; i < 4; i++) do_op(3'd2, 32'h0000_0000, -1);

        // Reset in the middle of an RWIM memory phase.
        chk_idle_outs();
        req_valid = 1'b1;
        req_op    = 3'd4;
        req_addr  = 32'h0000_3001;
        cyc();
        req_valid = 1'b0;
        for (int c = 1; c < SL + 3; c++) cyc();
        chk("rwim_busy", 64'(req_ready), 64'd0);
        rstb = 1'b0;
        #1;
        model_clr();
        chk_idle_outs();
        chk_cnt();
        cyc();
        chk_idle_outs();
        #2;
        rstb = 1'b1;
        do_op(3'd1, 32'h0000_0042, -1);

        do_op(3'd1, 32'h0000_0040, SL + ML + 1);

        for (int n = 0; n < 45; n++) begin
            if ($urandom_range(0, 9) < 8) rop = 3'($urandom_range(1, 4));
            else rop = bad_ops[$urandom_range(0, 3)];
            do_op(rop, $urandom,
                  ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 12)) : -1);
            if ($urandom_range(0, 3) == 0) begin
                cyc();
                chk_idle_outs();
                chk_cnt();
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
